// File: rtl/switch_arbiter.sv
// Round-robin arbiter sharing the switch input among NUM_REQ requesters, bursts of up to MAX_BURST beats.
// Latency: req->ack 1 cycle, ack->sw_* 1 cycle, one IDLE bubble between bursts; stall blocks acceptance.
module switch_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] ADDR_DIV = 'h3F,
    parameter int MAX_BURST = 4,
    localparam int IDW = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                          stall,
    input  logic                          clr_cnt,
    output logic [NUM_REQ-1:0]            ack,
    output logic [IDW-1:0]                gnt_id,
    output logic                          busy,
    output logic                          sw_vld,
    output logic [ADDR_WIDTH-1:0]         sw_addr,
    output logic [DATA_WIDTH-1:0]         sw_data,
    output logic [15:0]                   cnt_a,
    output logic [15:0]                   cnt_b
);
    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [IDW:0] NUM_REQ_W = (IDW+1)'(NUM_REQ);
    localparam logic [3:0]   LAST_BEAT = 4'(MAX_BURST - 1);

    state_t          state;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  owner;
    logic [3:0]      beat_cnt;
    logic            accept;
    logic            pick_vld;
    logic [IDW-1:0]  pick_id;
    logic [IDW-1:0]  cand;
    logic [IDW-1:0]  owner_nxt;
    logic [ADDR_WIDTH-1:0] owner_addr;
    logic [DATA_WIDTH-1:0] owner_data;

    logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g] = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign data_arr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // (base + ofs) mod NUM_REQ, valid for ofs < NUM_REQ
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input logic [IDW:0] ofs);
        logic [IDW:0] s;
        s = {1'b0, base} + ofs;
        return (s >= NUM_REQ_W) ? IDW'(s - NUM_REQ_W) : IDW'(s);
    endfunction

    assign owner_addr = addr_arr[owner];
    assign owner_data = data_arr[owner];
    assign owner_nxt  = wrap_add(owner, (IDW+1)'(1));
    assign accept     = (state == GRANT) & req[owner] & ~stall;
    assign gnt_id     = owner;
    assign busy       = (state == GRANT);

    always_comb begin
        ack        = '0;
        ack[owner] = accept;
    end

    // Scan downward so the nearest set bit at or after ptr wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        cand     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = wrap_add(ptr, (IDW+1)'(k));
            if (req[cand]) begin
                pick_vld = 1'b1;
                pick_id  = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            ptr      <= '0;
            owner    <= '0;
            beat_cnt <= '0;
            sw_vld   <= 1'b0;
            sw_addr  <= '0;
            sw_data  <= '0;
            cnt_a    <= '0;
            cnt_b    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        state    <= GRANT;
                        owner    <= pick_id;
                        beat_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (!req[owner]) begin
                        state <= IDLE;
                        ptr   <= owner_nxt;
                    end else if (!stall) begin
                        beat_cnt <= beat_cnt + 4'd1;
                        if (beat_cnt == LAST_BEAT) begin
                            state <= IDLE;
                            ptr   <= owner_nxt;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            sw_vld <= accept;
            if (accept) begin
                sw_addr <= owner_addr;
                sw_data <= owner_data;
            end

            if (clr_cnt) begin
                cnt_a <= '0;
                cnt_b <= '0;
            end else if (accept) begin
                if (owner_addr <= ADDR_DIV) begin
                    if (cnt_a != 16'hFFFF) cnt_a <= cnt_a + 16'd1;
                end else begin
                    if (cnt_b != 16'hFFFF) cnt_b <= cnt_b + 16'd1;
                end
            end
        end
    end
endmodule

// File: doc/switch_arbiter.md
# switch_arbiter

Round-robin arbiter that shares the single input of the address-routing switch between NUM_REQ requesters. It grants one requester at a time for bursts of up to MAX_BURST beats and drives registered vld/addr/data into the switch. It also keeps saturating counts of beats routed to the A side and the B side.

## Interface

Parameters
- NUM_REQ, 4: number of requesters, 2..8.
- ADDR_WIDTH, 8: address width.
- DATA_WIDTH, 16: data width.
- ADDR_DIV, 8'h3F: A/B split point; an address <= ADDR_DIV counts as A, otherwise B. Matches the switch setting.
- MAX_BURST, 4: maximum beats per grant, 1..15.

Ports
- clk  in  1  clock; all logic is on the rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- req  in  NUM_REQ  per-requester request; held high while the requester has a beat pending.
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened; requester i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_data  in  NUM_REQ*DATA_WIDTH  flattened; same layout as req_addr.
- stall  in  1  downstream hold; no beat is accepted while it is high.
- clr_cnt  in  1  synchronous clear of cnt_a and cnt_b.
- ack  out  NUM_REQ  combinational one-hot beat accept; the requester advances its beat on the clock edge where ack is high.
- gnt_id  out  $clog2(NUM_REQ)  registered index of the current owner.
- busy  out  1  high while in GRANT.
- sw_vld  out  1  registered valid to the switch.
- sw_addr  out  ADDR_WIDTH  registered address to the switch.
- sw_data  out  DATA_WIDTH  registered data to the switch.
- cnt_a  out  16  saturating count of accepted beats with addr <= ADDR_DIV.
- cnt_b  out  16  saturating count of accepted beats with addr > ADDR_DIV.

## Operation

- FSM has two states, IDLE and GRANT.
- IDLE: if any req bit is high, pick the first set bit searching upward from ptr with wrap-around. Load owner and gnt_id with that index, clear beat_cnt, and go to GRANT. No ack is issued in IDLE.
- GRANT, accept condition: accept = req[owner] & ~stall, and ack[owner] = accept. All other ack bits are 0.
- GRANT, on accept: increment beat_cnt.
  - If beat_cnt == MAX_BURST-1, go to IDLE and set ptr = owner+1 (mod NUM_REQ).
- GRANT, req[owner] low: go to IDLE with ptr = owner+1 and accept no beat. This holds even if stall is high.
- GRANT, stall high with req[owner] high: stay in GRANT; beat_cnt is unchanged.
- Switch outputs:
  - sw_vld <= accept.
  - On accept, sw_addr and sw_data are loaded from the owner's slice.
  - Otherwise sw_addr and sw_data hold their last value.
- Counters, on accept: increment cnt_a if the owner's addr <= ADDR_DIV, else increment cnt_b.
  - Both saturate at 16'hFFFF.
  - clr_cnt takes precedence over an increment in the same cycle.
- Reset values (async, rstn low): state=IDLE, ptr=0, owner=0, beat_cnt=0, gnt_id=0, busy=0, sw_vld=0, sw_addr=0, sw_data=0, cnt_a=0, cnt_b=0, ack=0.
- Reset mid-burst abandons the burst; no partial beat is emitted after reset releases.

## Timing

- Request to first ack: 1 cycle. req rises with the FSM in IDLE at cycle N; ack is high in cycle N+1.
- Accept to switch: ack at cycle N means sw_vld, sw_addr and sw_data are valid at N+1. The switch outputs appear at N+2.
- Peak throughput: 1 beat per cycle within a burst.
- Bubble: 1 IDLE cycle between bursts, including back-to-back bursts from the same requester.
- Fairness: after finishing its burst, a requester is served again only after every other active requester has had one grant.
- busy equals (state==GRANT) and is registered.
- gnt_id is valid while busy is high.

## Test plan

- Single requester, req[0] held for 6 beats, MAX_BURST=4, stall=0 -> ack[0] high for 4 cycles, then 1 idle cycle, then 2 more acks; sw_vld shows 4 beats, a 1-cycle gap, then 2 beats.
- All four req high continuously, MAX_BURST=1 -> grant order 0,1,2,3,0, with one ack every other cycle.
- Stall for 3 cycles mid-burst on requester 2 -> no ack and sw_vld=0 for those 3 cycles; the burst resumes, totals MAX_BURST beats, and gnt_id stays 2.
- Requester 1 sends addr 0x3F then 0x40, then 0x00 -> cnt_a=2, cnt_b=1; clr_cnt asserted together with a beat at addr 0x10 -> both counters 0 on the next cycle.
- Requester 3 drops req after 2 of 4 beats -> return to IDLE; the next grant goes to the lowest active index at or above 0 (wrap from 3+1).
- rstn pulsed low mid-burst -> all outputs 0 immediately; after release the first grant goes to the lowest active requester starting from index 0.
